// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch front-end definitions: FSM state encoding, instruction size and default vectors.
package fetch_sequencer_pkg;

    localparam int unsigned ILEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0004;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: one outstanding req/gnt/rvalid fetch, 3 cycles/instr min, decode stalls via if_ready.
// EX redirects flush and squash wrong-path fetches; PC_MISALIGN_TRAP_EN sends misaligned targets to TRAP_PC.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(TRAP_PC_DEF)
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCsrc,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready,
    output logic            flush,
    output logic            misalign
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_if_pc;
    logic [ILEN-1:0] r_if_instr;
    logic            r_if_valid;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_redirect;
    logic            w_grant;
    logic            w_accept;

    assign w_redirect = PCsrc & ex_valid;
    assign w_grant    = (r_state == S_REQ) & imem_gnt;
    assign w_accept   = (r_state == S_WAIT) & imem_rvalid & ~w_redirect;

`ifdef PC_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign;

    assign w_misaligned  = w_redirect & (target[1:0] != 2'b00);
    assign w_redirect_pc = w_misaligned ? TRAP_PC : target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misaligned;
        end
    end

    assign misalign = r_misalign;
`else
    assign w_redirect_pc = target & ~XLEN'(INSTR_BYTES - 1);
    assign misalign      = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    w_state_nxt = w_redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = w_redirect ? S_REQ : S_HOLD;
                end else if (w_redirect) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (if_ready || w_redirect) begin
                    w_state_nxt = S_REQ;
                end
            end
            // A redirect that lands with the stale response still ends the drop,
            // otherwise the FSM would wait for a response that never comes.
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_fetch_pc <= '0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
            r_if_valid <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_pc <= w_redirect_pc;
            end else if (w_grant) begin
                r_pc <= r_pc + XLEN'(INSTR_BYTES);
            end
            if (w_grant) begin
                r_fetch_pc <= r_pc;
            end
            if (w_accept) begin
                r_if_instr <= imem_rdata;
                r_if_pc    <= r_fetch_pc;
            end
            r_if_valid <= (w_state_nxt == S_HOLD);
        end
    end

    assign imem_req  = (r_state == S_REQ);
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign flush     = w_redirect & ~rst;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer against a transaction-level front-end model.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCsrc;
    logic        ex_valid;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        misalign;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] EXP_MIS_ADDR  = TRAP_PC_DEF;
    localparam logic [31:0] EXP_MIS_PULSE = 32'd1;
`else
    localparam logic [31:0] EXP_MIS_ADDR  = 32'h0000_0100;
    localparam logic [31:0] EXP_MIS_PULSE = 32'd0;
`endif

    fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .PCsrc      (PCsrc),
        .ex_valid   (ex_valid),
        .target     (target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .flush      (flush),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit tb_pend;

    // Front-end model: tracks whether a fetch is in flight, whether it is on the
    // wrong path, and whether decode is holding a word.
    bit          m_started, m_out, m_wrong, m_hold, m_mis;
    logic [31:0] m_pc, m_fpc, m_instr, m_ifpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_out = 0; m_wrong = 0; m_hold = 0; m_mis = 0;
        m_pc = RESET_PC_DEF; m_fpc = 0; m_instr = 0; m_ifpc = 0;
    endtask

    function automatic logic [31:0] redirect_pc(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00) ? TRAP_PC_DEF : t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic check_outputs();
        bit want_req;
        want_req = m_started && !m_out && !m_hold;
        chk("imem_req", 32'(imem_req), 32'(want_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_hold));
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", if_pc, m_ifpc);
        chk("flush", 32'(flush), 32'(!rst && PCsrc && ex_valid));
        chk("misalign", 32'(misalign), 32'(m_mis));
    endtask

    task automatic model_update();
        bit redir, req;
        redir = PCsrc && ex_valid;
        req   = m_started && !m_out && !m_hold;
        if (!m_started) begin
            m_started = 1;
        end else if (req && imem_gnt) begin
            m_out = 1; m_wrong = redir; m_fpc = m_pc; m_pc = m_pc + 32'd4;
        end else if (m_out && imem_rvalid) begin
            m_out = 0;
            if (!m_wrong && !redir) begin
                m_hold = 1; m_instr = imem_rdata; m_ifpc = m_fpc;
            end
        end else if (m_out && redir) begin
            m_wrong = 1;
        end else if (m_hold && if_ready) begin
            m_hold = 0;
        end
        if (redir) begin
            m_pc = redirect_pc(target);
            m_hold = 0;
        end
`ifdef PC_MISALIGN_TRAP_EN
        m_mis = redir && (target[1:0] != 2'b00);
`endif
    endtask

    // One clock: check at negedge, advance model at posedge, return at posedge+1.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (!rst) begin
            model_update();
            if (imem_rvalid) tb_pend = 0;
            if (imem_gnt) tb_pend = 1;
        end
        #1;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] data);
        for (int c = 0; c < 12; c++) begin
            if (if_valid) break;
            imem_gnt = imem_req; imem_rvalid = tb_pend; imem_rdata = data;
            cycle();
        end
        imem_gnt = 0; imem_rvalid = 0;
        chk(tag, 32'(if_valid), 32'd1);
    endtask

    initial begin
        int g, v;
        rst = 1; PCsrc = 0; ex_valid = 0; target = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_rdata = 0; if_ready = 0; tb_pend = 0;
        model_reset();
        #1;
        // Redirect held during reset must not flush
        PCsrc = 1; ex_valid = 1; target = 32'h40;
        repeat (2) cycle();
        PCsrc = 0; ex_valid = 0;
        cycle();
        rst = 0;

        // Zero-wait memory, first instruction
        if_ready = 1; g = -1; v = -1;
        for (int c = 0; c < 12 && v < 0; c++) begin
            imem_gnt = imem_req; imem_rvalid = tb_pend; imem_rdata = 32'h0000_0013;
            if (imem_req && g < 0) begin
                g = c;
                chk("first_addr", imem_addr, 32'h0);
            end
            if (if_valid) begin
                v = c;
                chk("first_if_pc", if_pc, 32'h0);
                chk("first_if_instr", if_instr, 32'h0000_0013);
            end
            cycle();
        end
        chk("if_valid_latency", 32'(v - g), 32'd2);
        chk("next_req", 32'(imem_req), 32'd1);
        chk("next_addr", imem_addr, 32'h4);

        // Decode stall for 5 cycles
        if_ready = 0;
        wait_valid("stall_valid", 32'h00A0_0093);
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_instr", if_instr, 32'h00A0_0093);
            chk("stall_pc", if_pc, 32'h4);
        end
        if_ready = 1;
        cycle();
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h8);

        // Redirect while waiting, stale response 3 cycles later
        imem_gnt = imem_req;
        cycle();
        imem_gnt = 0;
        PCsrc = 1; ex_valid = 1; target = 32'h100;
        #1;
        chk("redir_flush", 32'(flush), 32'd1);
        cycle();
        PCsrc = 0; ex_valid = 0;
        #1;
        chk("redir_flush_off", 32'(flush), 32'd0);
        chk("drop_req", 32'(imem_req), 32'd0);
        repeat (2) cycle();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        imem_rvalid = 0;
        chk("drop_valid", 32'(if_valid), 32'd0);
        chk("drop_req_after", 32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'h100);

        // Redirect coincident with rvalid in WAIT
        imem_gnt = imem_req;
        cycle();
        imem_gnt = 0;
        PCsrc = 1; ex_valid = 1; target = 32'h200; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
        cycle();
        PCsrc = 0; ex_valid = 0; imem_rvalid = 0;
        chk("coin_req", 32'(imem_req), 32'd1);
        chk("coin_addr", imem_addr, 32'h200);
        chk("coin_valid", 32'(if_valid), 32'd0);

        // PC wrap at top of address space
        PCsrc = 1; ex_valid = 1; target = 32'hFFFF_FFFC;
        cycle();
        PCsrc = 0; ex_valid = 0;
        chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = imem_req;
        cycle();
        imem_gnt = 0;
        chk("wrap_addr", imem_addr, 32'h0);
        if_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0073;
        cycle();
        imem_rvalid = 0;
        chk("wrap_if_valid", 32'(if_valid), 32'd1);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

        // Misaligned redirect from HOLD
        PCsrc = 1; ex_valid = 1; target = 32'h0000_0102;
        #1;
        chk("mis_flush", 32'(flush), 32'd1);
        cycle();
        PCsrc = 0; ex_valid = 0; if_ready = 1;
        chk("mis_pulse", 32'(misalign), EXP_MIS_PULSE);
        chk("mis_addr", imem_addr, EXP_MIS_ADDR);
        chk("mis_if_valid", 32'(if_valid), 32'd0);
        cycle();
        chk("mis_clear", 32'(misalign), 32'd0);

        // Reset mid-fetch, stray response afterwards
        imem_gnt = imem_req;
        cycle();
        imem_gnt = 0;
        rst = 1; model_reset();
        cycle();
        rst = 0; imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
        cycle();
        imem_rvalid = 0; tb_pend = 0;
        chk("stray_valid", 32'(if_valid), 32'd0);
        chk("stray_req", 32'(imem_req), 32'd1);
        chk("stray_addr", imem_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            PCsrc    = ($urandom_range(99) < 12);
            ex_valid = ($urandom_range(99) < 60);
            target   = $urandom;
            if ($urandom_range(9) == 0) target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            imem_gnt    = imem_req && ($urandom_range(99) < 60);
            imem_rvalid = tb_pend && ($urandom_range(99) < 50);
            imem_rdata  = $urandom;
            if_ready    = ($urandom_range(99) < 50);
            if ($urandom_range(399) == 0) begin
                imem_gnt = 0; imem_rvalid = 0; tb_pend = 0;
                rst = 1; model_reset();
                cycle();
                rst = 0;
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
